// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: receives the PS/2 keyboard serial stream and presents each
// decoded scan-code byte on ps2_out with a one-cycle ps2_key_pressed pulse.
// Bad parity, a bad stop bit or a stalled frame give a one-cycle frame_error.
// Optional feature: define PS2_BREAK_FILTER_EN to hide key-release codes
// (0xF0 and the byte that follows it) from the processor.
module ps2_keyboard_rx #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_key_pressed,
  output logic [7:0] ps2_out,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state, state_nxt;
  logic            clk_p0, clk_s, clk_d;
  logic            dat_p0, dat_s;
  logic            fall;
  logic [7:0]      shift;
  logic [2:0]      bitcnt;
  logic            par_q;
  logic [TW-1:0]   tcnt;
  logic            timeout;
  logic            frame_ok;
  logic            start_en, shift_en, par_en;
  logic            done_ok, done_err;
  logic            load_out;

  // Two-flop synchronizers on both pins, plus one more clock stage for edge detect
  always_ff @(posedge clock) begin
    if (reset) begin
      clk_p0 <= 1'b1;
      clk_s  <= 1'b1;
      clk_d  <= 1'b1;
      dat_p0 <= 1'b1;
      dat_s  <= 1'b1;
    end else begin
      clk_p0 <= ps2_clk_in;
      clk_s  <= clk_p0;
      clk_d  <= clk_s;
      dat_p0 <= ps2_data_in;
      dat_s  <= dat_p0;
    end
  end

  assign fall     = clk_d & ~clk_s;
  // A fall event in the same cycle as an expiring counter keeps the frame alive
  assign timeout  = (state != IDLE) && !fall && (tcnt == T_LAST);
  // Odd parity over data plus parity bit, and stop bit high
  assign frame_ok = dat_s && (par_q == ~^shift);

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and per-step control strobes; every step is taken on a fall event
  always_comb begin
    state_nxt = state;
    start_en  = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    done_ok   = 1'b0;
    done_err  = 1'b0;
    if (timeout) begin
      state_nxt = IDLE;
      done_err  = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE: begin
          if (!dat_s) begin
            state_nxt = DATA;
            start_en  = 1'b1;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          if (bitcnt == 3'd7) state_nxt = PARITY;
        end
        PARITY: begin
          par_en    = 1'b1;
          state_nxt = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          if (frame_ok) done_ok  = 1'b1;
          else          done_err = 1'b1;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef PS2_BREAK_FILTER_EN
  logic brk_pend, brk_nxt;

  // Break filter: 0xF0 arms the flag, the next good byte disarms it, both hidden
  always_comb begin
    brk_nxt  = brk_pend;
    load_out = 1'b0;
    if (done_err) begin
      brk_nxt = 1'b0;
    end else if (done_ok) begin
      if (brk_pend)              brk_nxt  = 1'b0;
      else if (shift == 8'hF0)   brk_nxt  = 1'b1;
      else                       load_out = 1'b1;
    end
  end

  // Break-pending flag register
  always_ff @(posedge clock) begin
    if (reset) brk_pend <= 1'b0;
    else       brk_pend <= brk_nxt;
  end
`else
  assign load_out = done_ok;
`endif

  // Frame datapath: bit assembly, parity capture, timeout counter, outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      shift           <= 8'h00;
      bitcnt          <= 3'd0;
      par_q           <= 1'b0;
      tcnt            <= '0;
      ps2_out         <= 8'h00;
      ps2_key_pressed <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      ps2_key_pressed <= load_out;
      frame_error     <= done_err;
      if (load_out) ps2_out <= shift;

      if (start_en) begin
        bitcnt <= 3'd0;
        shift  <= 8'h00;
      end
      if (shift_en) begin
        shift[bitcnt] <= dat_s;
        if (bitcnt != 3'd7) bitcnt <= bitcnt + 3'd1;
      end
      if (par_en) par_q <= dat_s;

      if (fall || state == IDLE || timeout) tcnt <= '0;
      else if (tcnt != '1)                  tcnt <= tcnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Testbench for ps2_keyboard_rx: directed table, hand-written timing/timeout/
// reset sequences, and random frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_ps2_keyboard_rx;

  localparam int TO = 2000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       kp;
  logic [7:0] out;
  logic       fe;

  ps2_keyboard_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clock          (clock),
    .reset          (reset),
    .ps2_clk_in     (ps2_clk),
    .ps2_data_in    (ps2_dat),
    .ps2_key_pressed(kp),
    .ps2_out        (out),
    .frame_error    (fe)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int kp_cnt = 0, fe_cnt = 0, both_viol = 0, stab_viol = 0;
  logic [7:0] prev_out = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Pulse monitor, sampled 1 ns after each rising edge
  always @(posedge clock) begin
    #1;
    if (!reset) begin
      if (kp) kp_cnt++;
      if (fe) fe_cnt++;
      if (kp && fe) both_viol++;
      if (!kp && out !== prev_out) stab_viol++;
    end
    prev_out = out;
  end

  // Frame-level reference: what the processor should see for each frame
  bit         brk_m = 1'b0;
  logic [7:0] out_m = 8'h00;

  task automatic model_frame(input logic [7:0] d, input bit par, input bit stop,
                             output int ek, output int ee);
    bit valid;
    valid = stop && ((^d ^ par) == 1'b1);
    ek = 0;
    ee = 0;
    if (!valid) begin
      ee = 1;
      brk_m = 1'b0;
    end else begin
`ifdef PS2_BREAK_FILTER_EN
      if (brk_m)            brk_m = 1'b0;
      else if (d == 8'hF0)  brk_m = 1'b1;
      else begin ek = 1; out_m = d; end
`else
      ek = 1;
      out_m = d;
`endif
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_bit(input bit b, input int half);
    ps2_dat = b;
    wait_clk(half);
    ps2_clk = 1'b0;
    wait_clk(half);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par, input bit stop, input int half);
    send_bit(1'b0, half);
    for (int i = 0; i < 8; i++) send_bit(d[i], half);
    send_bit(par, half);
    send_bit(stop, half);
    ps2_dat = 1'b1;
    wait_clk(half);
  endtask

  task automatic run_frame(input string name, input logic [7:0] d, input bit par,
                           input bit stop, input int half);
    int k0, f0, ek, ee;
    k0 = kp_cnt;
    f0 = fe_cnt;
    model_frame(d, par, stop, ek, ee);
    send_frame(d, par, stop, half);
    wait_clk(6);
    check({name, " key"}, kp_cnt - k0, ek);
    check({name, " err"}, fe_cnt - f0, ee);
    check({name, " out"}, int'(out), int'(out_m));
  endtask

  typedef struct {
    logic [7:0] d;
    bit         par;
    bit         stop;
    int         ek;
    int         ee;
    logic [7:0] eo;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int k0, f0, n;
    logic [7:0] d;
    bit par, stop;

    tbl[0] = '{8'h29, 1'b0, 1'b1, 1, 0, 8'h29};
    tbl[1] = '{8'h1C, 1'b1, 1'b1, 0, 1, 8'h29};  // parity error
    tbl[2] = '{8'h5A, 1'b1, 1'b0, 0, 1, 8'h29};  // stop-bit error
    tbl[3] = '{8'h5A, 1'b1, 1'b1, 1, 0, 8'h5A};  // accepted right after stop error
    tbl[4] = '{8'h00, 1'b1, 1'b1, 1, 0, 8'h00};
    tbl[5] = '{8'hFF, 1'b1, 1'b1, 1, 0, 8'hFF};
    tbl[6] = '{8'hE0, 1'b0, 1'b1, 1, 0, 8'hE0};
    tbl[7] = '{8'hFF, 1'b0, 1'b1, 0, 1, 8'hE0};  // parity error

    // Reset state
    wait_clk(4);
    reset = 1'b0;
    wait_clk(2);
    check("reset out", int'(out), 0);
    check("reset key", int'(kp), 0);
    check("reset err", int'(fe), 0);

    // Single valid 0x1C frame, half-period 200, with pulse latency
    k0 = kp_cnt; f0 = fe_cnt;
    d = 8'h1C;
    send_bit(1'b0, 200);
    for (int i = 0; i < 8; i++) send_bit(d[i], 200);
    send_bit(1'b0, 200);
    ps2_dat = 1'b1;
    wait_clk(200);
    ps2_clk = 1'b0;
    @(posedge clock); #2; check("lat edge1 key", int'(kp), 0);
    @(posedge clock); #2; check("lat edge2 key", int'(kp), 0);
    @(posedge clock); #2; check("lat edge3 key", int'(kp), 1);
    check("lat edge3 out", int'(out), 8'h1C);
    @(posedge clock); #2; check("lat edge4 key", int'(kp), 0);
    wait_clk(200);
    ps2_clk = 1'b1;
    wait_clk(200);
    check("single key count", kp_cnt - k0, 1);
    check("single err count", fe_cnt - f0, 0);
    check("single out", int'(out), 8'h1C);
    out_m = 8'h1C;

    // Directed vector table
    for (int i = 0; i < 8; i++) begin
      k0 = kp_cnt; f0 = fe_cnt;
      send_frame(tbl[i].d, tbl[i].par, tbl[i].stop, 20);
      wait_clk(6);
      check($sformatf("tbl%0d key", i), kp_cnt - k0, tbl[i].ek);
      check($sformatf("tbl%0d err", i), fe_cnt - f0, tbl[i].ee);
      check($sformatf("tbl%0d out", i), int'(out), int'(tbl[i].eo));
      out_m = tbl[i].eo;
    end

    // Break filter sequence 0x1C, 0xF0, 0x1C
    k0 = kp_cnt;
    run_frame("brk 1C", 8'h1C, 1'b0, 1'b1, 20);
    run_frame("brk F0", 8'hF0, 1'b1, 1'b1, 20);
    run_frame("brk 1C again", 8'h1C, 1'b0, 1'b1, 20);
`ifdef PS2_BREAK_FILTER_EN
    check("brk total pulses", kp_cnt - k0, 1);
`else
    check("brk total pulses", kp_cnt - k0, 3);
`endif
    check("brk final out", int'(out), 8'h1C);

    // Timeout: start plus 4 data bits of 0x29, then the clock stays high
    k0 = kp_cnt; f0 = fe_cnt;
    d = 8'h29;
    send_bit(1'b0, 20);
    for (int i = 0; i < 3; i++) send_bit(d[i], 20);
    ps2_dat = d[3];
    wait_clk(20);
    ps2_clk = 1'b0;
    for (n = 1; n <= 3000; n++) begin
      @(posedge clock); #2;
      if (n == 20) ps2_clk = 1'b1;
      if (fe) break;
    end
    ps2_clk = 1'b1;
    check("timeout latency", n, 2003);
    wait_clk(10);
    check("timeout err count", fe_cnt - f0, 1);
    check("timeout key count", kp_cnt - k0, 0);
    check("timeout out", int'(out), int'(out_m));
    brk_m = 1'b0;
    run_frame("after timeout 29", 8'h29, 1'b0, 1'b1, 20);

    // Reset in the middle of a 0x1C frame
    d = 8'h1C;
    send_bit(1'b0, 20);
    for (int i = 0; i < 4; i++) send_bit(d[i], 20);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset out", int'(out), 0);
    check("midreset key", int'(kp), 0);
    check("midreset err", int'(fe), 0);
    out_m = 8'h00;
    brk_m = 1'b0;
    k0 = kp_cnt;
    for (int i = 4; i < 8; i++) send_bit(d[i], 20);
    send_bit(1'b0, 20);
    send_bit(1'b1, 20);
    wait_clk(TO + 100);
    check("midreset tail key", kp_cnt - k0, 0);
    check("midreset tail out", int'(out), 0);
    brk_m = 1'b0;
    run_frame("post reset 29", 8'h29, 1'b0, 1'b1, 20);

    // Random frames against the reference model
    for (int i = 0; i < 25; i++) begin
      d = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'hF0;
      par = ~^d;
      if ($urandom_range(0, 3) == 0) par = ~par;
      stop = ($urandom_range(0, 7) != 0);
      run_frame($sformatf("rnd%0d", i), d, par, stop, int'($urandom_range(3, 25)));
    end

    check("key and err never together", both_viol, 0);
    check("out changes only with key pulse", stab_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receives the PS/2 keyboard serial stream (device-driven clock and data lines) and delivers decoded scan-code bytes to the processor's keyboard input pair, `ps2_key_pressed` / `ps2_out[7:0]`. It is the producing end of that interface: the processor's TTY instruction reads `ps2_out` directly as a 32-bit zero-extended value. It sits between the board PS/2 pins and the processor top level, in the processor's clock domain.

## Interface

- `TIMEOUT_CYCLES`, default 100000, is the maximum number of system clocks between PS/2 clock falling edges inside a frame before the frame is aborted. At 50 MHz this is 2 ms. Legal values are ≥ 16.
- `clock` input 1: system clock. Everything is on the rising edge.
- `reset` input 1: reset is synchronous and active-high.
- `ps2_clk_in` input 1: raw PS/2 clock pin. It is asynchronous.
- `ps2_data_in` input 1: raw PS/2 data pin. It is asynchronous.
- `ps2_key_pressed` output 1: one-cycle pulse when a new byte is placed on `ps2_out`.
- `ps2_out` output 8: last accepted scan-code byte. It is held until the next accepted byte.
- `frame_error` output 1: one-cycle pulse on a parity, stop-bit or timeout failure.

## Operation

- Both pins pass through 2-flop synchronizers, giving `clk_s` and `dat_s`.
- `clk_s` is registered again to form `clk_d`. A fall event occurs when `clk_d`=1 and `clk_s`=0. `dat_s` is sampled in the same cycle as the fall event.
- Frame format is 11 bits: start bit 0, then 8 data bits LSB first, then parity (odd over data plus parity), then stop bit 1.
- FSM states, each step taken on a fall event:
  - IDLE: a fall with data 0 goes to DATA with the bit counter at 0. A fall with data 1 is ignored and raises no error.
  - DATA: the bit is shifted into `shift[7:0]` at position `bitcnt`. When `bitcnt`=7, go to PARITY; otherwise increment `bitcnt`.
  - PARITY: store the parity bit and go to STOP.
  - STOP: go to IDLE and evaluate the frame.
    - The frame is valid when the stop bit is 1 and the parity bit equals `~^shift`.
    - Valid frame: `ps2_out` ← `shift` and pulse `ps2_key_pressed` (subject to Configuration).
    - Invalid frame: pulse `frame_error` and leave `ps2_out` unchanged.
- Timeout counter:
  - Clears on every fall event and while in IDLE.
  - Increments in every other cycle while not in IDLE.
  - When it reaches `TIMEOUT_CYCLES`-1 → go to IDLE, pulse `frame_error`, discard the partial byte.
  - If a fall event and a timeout occur in the same cycle, the fall event wins and the counter clears.
- The counter width is `$clog2(TIMEOUT_CYCLES)` and it saturates rather than wrapping.
- `ps2_key_pressed` and `frame_error` are never asserted in the same cycle.
- Reset values: `ps2_out`=0x00, `ps2_key_pressed`=0, `frame_error`=0, FSM=IDLE, `shift`=0, `bitcnt`=0, timeout counter=0, synchronizers=1, `clk_d`=1, break-pending flag=0.
- Reset asserted mid-frame aborts the frame immediately with no pulse. The first fall event after reset deasserts is treated as a potential start bit.

## Timing

- A PS/2 clock falling edge first sampled low at rising edge k produces the fall event in cycle k+2.
- The output pulse for a stop bit is registered and asserted in cycle k+3 for exactly one clock.
- `ps2_out` updates in the same cycle the pulse asserts and is stable thereafter.
- Minimum fall-event spacing supported is 4 system clocks. Real PS/2 timing is 60–100 µs per bit.
- No back-pressure. A byte not consumed before the next arrives is overwritten.

## Configuration

- `PS2_BREAK_FILTER_EN`
  - Defined:
    - A valid 0xF0 byte sets break-pending. It updates neither `ps2_out` nor `ps2_key_pressed`.
    - The next valid byte clears break-pending and is also suppressed, so key releases are invisible to the processor.
    - 0xE0 passes through normally.
    - A `frame_error` clears break-pending.
  - Undefined: every valid byte, including 0xF0, is reported, and the break-pending flag is not built.

## Test plan

- **Single frame, valid byte.** Setup: `TIMEOUT_CYCLES`=2000, PS/2 bit half-period 200 clocks. Stimulus: frame 0x1C with parity 0 and stop 1. Expected: one `ps2_key_pressed` pulse 3 clocks after the stop-bit fall, `ps2_out`=0x1C, `frame_error` stays 0.
- **Parity error.** Stimulus: 0x1C with parity 1, after a prior valid 0x29. Expected: one `frame_error` pulse, no `ps2_key_pressed`, `ps2_out` stays 0x29.
- **Timeout recovery.** Stimulus: start bit plus 4 data bits, clock held high 2000+ cycles, then a valid 0x29 frame. Expected: `frame_error` pulses once near cycle 2000 after the last fall, then 0x29 is delivered with one `ps2_key_pressed` pulse.
- **Stop-bit error.** Stimulus: 0x5A with parity 1 and stop 0. Expected: `frame_error` pulse, `ps2_out` unchanged, then the FSM is in IDLE and accepts the next valid frame.
- **Break filter.** Stimulus: frames 0x1C, 0xF0, 0x1C.
  - With `PS2_BREAK_FILTER_EN`: one pulse total, `ps2_out`=0x1C.
  - Without: three pulses, `ps2_out` sequence 0x1C, 0xF0, 0x1C.
- **Reset mid-frame.** Stimulus: `reset` asserted for 1 cycle after 5 bits of a 0x1C frame, remaining bits sent, then a full 0x29 frame. Expected:
  - Immediately after reset: outputs 0x00 / 0 / 0.
  - The tail bits produce no `ps2_key_pressed`. A `frame_error` is allowed only from a misframed start.
  - 0x29 is delivered correctly once the line idles for `TIMEOUT_CYCLES`.
